// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches from instruction memory, issues non-branch
// instructions into a single IR, resolves JMP/JNZ/ZNJ redirects locally and
// detects the JMP end-loop that signals program completion.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter logic [3:0] OP_JMP   = 4'h1,
  parameter logic [3:0] OP_JNZ   = 4'h2,
  parameter logic [3:0] OP_ZNJ   = 4'h3,
  parameter logic [3:0] OP_CHECK = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc,
  input  logic [31:0] op,
  input  logic        stall,
  input  logic        flag_valid,
  input  logic        flag_nz,
  output logic [31:0] ir_op,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [15:0] br_cnt
);

  typedef enum logic [1:0] {RUN, WAIT_FLAG, HALT} state_t;

  state_t      state;
  logic        flag_ready;
  logic        flag_val;
  logic        prev_jmp;
  logic [7:0]  prev_jmp_pc;
  logic        wait_jnz;
  logic [7:0]  wait_target;

  logic [3:0]  opcode;
  logic [7:0]  target;
  logic        slot_open;
  logic        is_jmp;
  logic        is_cond;
  logic        flag_now;
  logic        cond_taken;
  logic        wait_taken;
  logic        jmp_halt;
  logic        issue_check;
  logic [7:0]  pc_inc;
  logic [15:0] br_cnt_inc;

  assign opcode      = op[31:28];
  assign target      = op[27:20];
  assign slot_open   = ~ir_valid | ~stall;
  assign is_jmp      = (opcode == OP_JMP);
  assign is_cond     = (opcode == OP_JNZ) || (opcode == OP_ZNJ);
  // A flag arriving this cycle is fresher than the stored one.
  assign flag_now    = flag_valid ? flag_nz : flag_val;
  assign cond_taken  = (opcode == OP_JNZ) ? flag_now : ~flag_now;
  assign wait_taken  = wait_jnz ? flag_nz : ~flag_nz;
  assign jmp_halt    = (target == pc) || (prev_jmp && (target == prev_jmp_pc));
  assign issue_check = (state == RUN) && slot_open && (opcode == OP_CHECK);
  assign pc_inc      = pc + 8'd1;
  assign br_cnt_inc  = (br_cnt == 16'hFFFF) ? br_cnt : br_cnt + 16'd1;

  // Sticky CHECK result; a new result beats the clear from issuing a CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_ready <= 1'b0;
      flag_val   <= 1'b0;
    end else if (state != HALT) begin
      if (flag_valid) begin
        flag_ready <= 1'b1;
        flag_val   <= flag_nz;
      end else if (issue_check) begin
        flag_ready <= 1'b0;
      end
    end
  end

  // Fetch/issue state machine with branch resolution and end-loop detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      ir_op       <= 32'd0;
      ir_pc       <= 8'd0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      br_cnt      <= 16'd0;
      prev_jmp    <= 1'b0;
      prev_jmp_pc <= 8'd0;
      wait_jnz    <= 1'b0;
      wait_target <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (slot_open) begin
            if (is_jmp) begin
              ir_valid    <= 1'b0;
              pc          <= target;
              br_cnt      <= br_cnt_inc;
              prev_jmp    <= 1'b1;
              prev_jmp_pc <= pc;
              if (jmp_halt) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end else if (is_cond) begin
              ir_valid <= 1'b0;
              prev_jmp <= 1'b0;
              if (flag_valid || flag_ready) begin
                if (cond_taken) begin
                  pc     <= target;
                  br_cnt <= br_cnt_inc;
                end else begin
                  pc <= pc_inc;
                end
              end else begin
                state       <= WAIT_FLAG;
                wait_jnz    <= (opcode == OP_JNZ);
                wait_target <= target;
              end
            end else begin
              ir_op    <= op;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              pc       <= pc_inc;
              prev_jmp <= 1'b0;
            end
          end
        end
        WAIT_FLAG: begin
          if (flag_valid) begin
            state <= RUN;
            if (wait_taken) begin
              pc     <= wait_target;
              br_cnt <= br_cnt_inc;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HALT: begin
          if (!stall) begin
            ir_valid <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run against
// an instruction-level reference model.
module tb_fetch_unit;

  localparam logic [3:0] OP_JMP   = 4'h1;
  localparam logic [3:0] OP_JNZ   = 4'h2;
  localparam logic [3:0] OP_ZNJ   = 4'h3;
  localparam logic [3:0] OP_CHECK = 4'h4;
  localparam logic [3:0] OP_NOP   = 4'h0;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic [31:0] op;
  logic        stall;
  logic        flag_valid;
  logic        flag_nz;
  logic [31:0] ir_op;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] br_cnt;

  logic [31:0] imem [256];
  int n_checks;
  int n_fail;

  fetch_unit #(
    .RESET_PC(8'd0), .OP_JMP(OP_JMP), .OP_JNZ(OP_JNZ),
    .OP_ZNJ(OP_ZNJ), .OP_CHECK(OP_CHECK)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .op(op), .stall(stall),
    .flag_valid(flag_valid), .flag_nz(flag_nz), .ir_op(ir_op),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted), .br_cnt(br_cnt)
  );

  assign op = imem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] code, input logic [7:0] tgt, input logic [19:0] lo);
    return {code, tgt, lo};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = mk(OP_NOP, 8'(i), 20'h5A000 + 20'(i));
  endtask

  task automatic do_reset();
    stall = 1'b0; flag_valid = 1'b0; flag_nz = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_mem();
    imem[2] = mk(OP_JMP, 8'd40, 20'h0);
    do_reset();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (pc !== 8'd0 || ir_op !== 32'd0 || ir_pc !== 8'd0 || ir_valid !== 1'b0 || halted !== 1'b0 || br_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: pc=%0d ir_op=%h ir_pc=%0d v=%b h=%b br=%0d, expected all zero", pc, ir_op, ir_pc, ir_valid, halted, br_cnt);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_straight_line();
    clear_mem();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (ir_pc !== 8'(k) || ir_valid !== 1'b1 || ir_op !== imem[k] || br_cnt !== 16'd0) begin
        n_fail++;
        $display("[TB] FAIL straight_%0d: ir_pc=%0d v=%b br=%0d, expected ir_pc=%0d v=1 br=0", k, ir_pc, ir_valid, br_cnt, k);
      end
    end
  endtask

  task automatic test_jmp();
    clear_mem();
    imem[1] = mk(OP_JMP, 8'd13, 20'h0);
    do_reset();
    tick();
    n_checks++;
    if (ir_pc !== 8'd0 || ir_valid !== 1'b1 || pc !== 8'd1) begin
      n_fail++; $display("[TB] FAIL jmp_first: ir_pc=%0d v=%b pc=%0d, expected 0 1 1", ir_pc, ir_valid, pc);
    end
    tick();
    n_checks++;
    if (pc !== 8'd13 || ir_valid !== 1'b0 || br_cnt !== 16'd1) begin
      n_fail++; $display("[TB] FAIL jmp_bubble: pc=%0d v=%b br=%0d, expected 13 0 1", pc, ir_valid, br_cnt);
    end
    tick();
    n_checks++;
    if (ir_pc !== 8'd13 || ir_valid !== 1'b1 || pc !== 8'd14) begin
      n_fail++; $display("[TB] FAIL jmp_target_issue: ir_pc=%0d v=%b pc=%0d, expected 13 1 14", ir_pc, ir_valid, pc);
    end
  endtask

  task automatic test_cond_wait(input logic nz, input logic [7:0] exp_pc, input logic [15:0] exp_br);
    clear_mem();
    imem[0] = mk(OP_CHECK, 8'd0, 20'h0);
    imem[1] = mk(OP_JNZ, 8'd29, 20'h0);
    do_reset();
    tick();
    n_checks++;
    if (ir_valid !== 1'b1 || ir_op[31:28] !== OP_CHECK || pc !== 8'd1) begin
      n_fail++; $display("[TB] FAIL cond_check_issue: v=%b op=%h pc=%0d", ir_valid, ir_op, pc);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (pc !== 8'd1 || ir_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL cond_wait_%0d: pc=%0d v=%b, expected pc=1 v=0", k, pc, ir_valid);
      end
    end
    flag_valid = 1'b1; flag_nz = nz;
    tick();
    flag_valid = 1'b0; flag_nz = 1'b0;
    n_checks++;
    if (pc !== exp_pc || ir_valid !== 1'b0 || br_cnt !== exp_br) begin
      n_fail++; $display("[TB] FAIL cond_resolve_nz%0d: pc=%0d br=%0d, expected pc=%0d br=%0d", nz, pc, br_cnt, exp_pc, exp_br);
    end
  endtask

  task automatic test_znj_ready();
    clear_mem();
    imem[1] = mk(OP_ZNJ, 8'd50, 20'h0);
    do_reset();
    flag_valid = 1'b1; flag_nz = 1'b0;
    tick();
    flag_valid = 1'b0; flag_nz = 1'b1;
    tick();
    n_checks++;
    if (pc !== 8'd50 || ir_valid !== 1'b0 || br_cnt !== 16'd1) begin
      n_fail++; $display("[TB] FAIL znj_ready: pc=%0d v=%b br=%0d, expected 50 0 1", pc, ir_valid, br_cnt);
    end
    tick();
    n_checks++;
    if (ir_pc !== 8'd50 || ir_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL znj_no_wait: ir_pc=%0d v=%b, expected 50 1", ir_pc, ir_valid);
    end
  endtask

  task automatic test_end_loop();
    clear_mem();
    imem[0]  = mk(OP_JMP, 8'd71, 20'h0);
    imem[71] = mk(OP_JMP, 8'd72, 20'h0);
    imem[72] = mk(OP_JMP, 8'd71, 20'h0);
    do_reset();
    tick(); tick();
    n_checks++;
    if (halted !== 1'b0 || pc !== 8'd72) begin
      n_fail++; $display("[TB] FAIL loop_pre: halted=%b pc=%0d, expected 0 72", halted, pc);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (halted !== 1'b1 || pc !== 8'd71 || ir_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL loop_halt_%0d: halted=%b pc=%0d v=%b, expected 1 71 0", k, halted, pc, ir_valid);
      end
      stall = 1'($urandom_range(0, 1)); flag_valid = 1'($urandom_range(0, 1)); flag_nz = 1'($urandom_range(0, 1));
      tick();
    end
    do_reset();
    n_checks++;
    if (halted !== 1'b0 || pc !== 8'd0) begin
      n_fail++; $display("[TB] FAIL loop_reset: halted=%b pc=%0d, expected 0 0", halted, pc);
    end
  endtask

  task automatic test_stall_wrap();
    clear_mem();
    imem[1] = mk(OP_JMP, 8'd200, 20'h0);
    do_reset();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'd0 || ir_op !== imem[0] || pc !== 8'd1 || br_cnt !== 16'd0) begin
        n_fail++; $display("[TB] FAIL stall_hold_%0d: v=%b ir_pc=%0d pc=%0d br=%0d, expected 1 0 1 0", k, ir_valid, ir_pc, pc, br_cnt);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc !== 8'd200 || br_cnt !== 16'd1 || ir_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_release: pc=%0d br=%0d v=%b, expected 200 1 0", pc, br_cnt, ir_valid);
    end
    clear_mem();
    imem[0] = mk(OP_JMP, 8'd255, 20'h0);
    do_reset();
    tick(); tick();
    n_checks++;
    if (ir_pc !== 8'd255 || ir_valid !== 1'b1 || pc !== 8'd0) begin
      n_fail++; $display("[TB] FAIL wrap: ir_pc=%0d v=%b pc=%0d, expected 255 1 0", ir_pc, ir_valid, pc);
    end
  endtask

  task automatic test_random();
    logic [7:0]  m_pc, m_irpc, m_pjpc, m_wt, t;
    logic [31:0] m_irop, o;
    logic [15:0] m_br;
    logic [3:0]  c;
    logic        m_irv, m_halt, m_wait, m_fr, m_fv, m_pj, m_wjnz, f, take;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 9))
        0:       imem[i] = mk(OP_JMP, 8'($urandom), 20'($urandom));
        1:       imem[i] = mk(OP_JNZ, 8'($urandom), 20'($urandom));
        2:       imem[i] = mk(OP_ZNJ, 8'($urandom), 20'($urandom));
        3:       imem[i] = mk(OP_CHECK, 8'($urandom), 20'($urandom));
        default: imem[i] = mk(4'($urandom_range(5, 15)), 8'($urandom), 20'($urandom));
      endcase
    end
    m_halt = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (m_halt || $urandom_range(0, 149) == 0) begin
        do_reset();
        m_pc = 8'd0; m_irpc = 8'd0; m_irop = 32'd0; m_irv = 1'b0; m_halt = 1'b0; m_br = 16'd0;
        m_wait = 1'b0; m_fr = 1'b0; m_fv = 1'b0; m_pj = 1'b0; m_pjpc = 8'd0; m_wjnz = 1'b0; m_wt = 8'd0;
      end
      stall = ($urandom_range(0, 3) == 0);
      flag_valid = ($urandom_range(0, 5) == 0);
      flag_nz = 1'($urandom_range(0, 1));
      if (!m_halt) begin
        if (m_wait) begin
          if (flag_valid) begin
            take = m_wjnz ? flag_nz : !flag_nz;
            if (take) begin m_pc = m_wt; if (m_br != 16'hFFFF) m_br++; end
            else m_pc = m_pc + 8'd1;
            m_wait = 1'b0;
          end
        end else if (!m_irv || !stall) begin
          o = imem[m_pc]; c = o[31:28]; t = o[27:20];
          if (c == OP_JMP) begin
            m_halt = (t == m_pc) || (m_pj && t == m_pjpc);
            m_pj = 1'b1; m_pjpc = m_pc; m_pc = t; m_irv = 1'b0;
            if (m_br != 16'hFFFF) m_br++;
          end else if (c == OP_JNZ || c == OP_ZNJ) begin
            m_irv = 1'b0; m_pj = 1'b0;
            if (flag_valid || m_fr) begin
              f = flag_valid ? flag_nz : m_fv;
              take = (c == OP_JNZ) ? f : !f;
              if (take) begin m_pc = t; if (m_br != 16'hFFFF) m_br++; end
              else m_pc = m_pc + 8'd1;
            end else begin
              m_wait = 1'b1; m_wjnz = (c == OP_JNZ); m_wt = t;
            end
          end else begin
            m_irop = o; m_irpc = m_pc; m_irv = 1'b1; m_pc = m_pc + 8'd1; m_pj = 1'b0;
            if (c == OP_CHECK) m_fr = 1'b0;
          end
        end
        if (flag_valid) begin m_fr = 1'b1; m_fv = flag_nz; end
      end
      tick();
      n_checks++;
      if (pc !== m_pc || ir_valid !== m_irv || ir_pc !== m_irpc || ir_op !== m_irop || halted !== m_halt || br_cnt !== m_br) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: pc=%0d v=%b ir_pc=%0d ir_op=%h h=%b br=%0d, expected pc=%0d v=%b ir_pc=%0d ir_op=%h h=%b br=%0d",
                 cyc, pc, ir_valid, ir_pc, ir_op, halted, br_cnt, m_pc, m_irv, m_irpc, m_irop, m_halt, m_br);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; stall = 1'b0; flag_valid = 1'b0; flag_nz = 1'b0;
    clear_mem();
    test_reset();
    test_straight_line();
    test_jmp();
    test_cond_wait(1'b1, 8'd29, 16'd1);
    test_cond_wait(1'b0, 8'd2, 16'd0);
    test_znj_ready();
    test_end_loop();
    test_stall_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
